// File: rtl/frame_pkg.sv
// Shared constants for the Ethernet/IPv4/UDP frame builder: FSM encoding,
// protocol constants, header byte offsets and a field byte-select helper.
package frame_pkg;

    localparam int unsigned LEN_W         = 11;
    localparam int unsigned HDR_BYTES     = 42;
    localparam int unsigned MIN_FRAME     = 60;
    localparam int unsigned MIN_PAYLOAD   = MIN_FRAME - HDR_BYTES;
    localparam int unsigned CSUM_WORDS    = 10;
    localparam int unsigned IP_HDR_BYTES  = 20;
    localparam int unsigned UDP_HDR_BYTES = 8;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
    localparam logic [7:0]  IP_TTL         = 8'h40;
    localparam logic [15:0] UDP_NO_CSUM    = 16'h0000;

    // Byte offsets of each header field within the 42-byte header
    localparam int unsigned OFF_DST_MAC   = 0;
    localparam int unsigned OFF_SRC_MAC   = 6;
    localparam int unsigned OFF_ETYPE     = 12;
    localparam int unsigned OFF_IP_VER    = 14;
    localparam int unsigned OFF_IP_TOTLEN = 16;
    localparam int unsigned OFF_IP_ID     = 18;
    localparam int unsigned OFF_IP_FLAGS  = 20;
    localparam int unsigned OFF_IP_TTL    = 22;
    localparam int unsigned OFF_IP_PROTO  = 23;
    localparam int unsigned OFF_IP_CSUM   = 24;
    localparam int unsigned OFF_IP_SRC    = 26;
    localparam int unsigned OFF_IP_DST    = 30;
    localparam int unsigned OFF_UDP_SRC   = 34;
    localparam int unsigned OFF_UDP_DST   = 36;
    localparam int unsigned OFF_UDP_LEN   = 38;
    localparam int unsigned OFF_UDP_CSUM  = 40;

    typedef enum logic [7:0] {
        S_IDLE = 8'b0000_0001,
        S_CSUM = 8'b0000_0010,
        S_TRIG = 8'b0000_0100,
        S_HDR  = 8'b0000_1000,
        S_PAY  = 8'b0001_0000,
        S_PAD  = 8'b0010_0000,
        S_WAIT = 8'b0100_0000
    } state_e;

    // Big-endian byte `rel` of a right-aligned field that is `nbytes` wide
    function automatic logic [7:0] field_byte(input logic [47:0] v,
                                              input int unsigned nbytes,
                                              input int unsigned rel);
        logic [47:0] sh;
        sh = v << (8 * (6 - nbytes + rel));
        return sh[47:40];
    endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// Sequential ones-complement checksum over 16-bit words.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clr zeroes the
// accumulator; i_en adds i_word; o_csum is the complemented, twice-folded sum.
module ip_hdr_csum (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [15:0] i_word,
    output logic [15:0] o_csum
);

    logic [19:0] acc_q;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // 20 bits hold up to 16 full-scale words without overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
        end else if (i_clr) begin
            acc_q <= '0;
        end else if (i_en) begin
            acc_q <= acc_q + 20'(i_word);
        end
    end

    // Second fold absorbs the at-most-one carry left by the first
    always_comb begin
        fold1  = 17'(acc_q[15:0]) + 17'(acc_q[19:16]);
        fold2  = fold1[15:0] + 16'(fold1[16]);
        o_csum = ~fold2;
    end

endmodule

// File: rtl/udp_frame_builder.sv
// Builds one Ethernet/IPv4/UDP frame per accepted start and streams it
// bytewise into the TX MAC (trig/data/last), then waits for tx_over.
// Ports: i_clk, i_rst_n (async, active-low); i_start/i_len request a frame;
// o_busy while a frame is in flight; o_rd_addr/i_rd_data payload RAM
// (1-cycle latency); o_tx_trig/o_data/o_last_data to the MAC; i_tx_over
// from the MAC.
module udp_frame_builder
    import frame_pkg::*;
#(
    parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC  = 48'h0012_3456_789A,
    parameter logic [31:0] SRC_IP   = 32'hC0A8_010A,
    parameter logic [31:0] DST_IP   = 32'hC0A8_0102,
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd5001,
    parameter int unsigned MAX_LEN  = 1472,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [10:0]       i_len,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic              o_tx_trig,
    output logic [7:0]        o_data,
    output logic              o_last_data,
    input  logic              i_tx_over
);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              trig_q, trig_d;
    logic [7:0]        data_q, data_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [15:0]       ip_id_q, ip_id_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        hdr_cnt_q, hdr_cnt_d;

    logic              csum_clr_c;
    logic              csum_en_c;
    logic [15:0]       csum_word_c;
    logic [15:0]       hdr_csum_c;
    logic [15:0]       tot_len_c;
    logic [15:0]       udp_len_c;
    logic [7:0]        hdr_byte_c;
    logic [LEN_W-1:0]  pad_last_c;
    logic              rd_more_c;

    assign o_busy      = busy_q;
    assign o_tx_trig   = trig_q;
    assign o_data      = data_q;
    assign o_last_data = last_q;
    assign o_rd_addr   = rd_addr_q;

    assign tot_len_c  = 16'(len_q) + 16'(IP_HDR_BYTES + UDP_HDR_BYTES);
    assign udp_len_c  = 16'(len_q) + 16'(UDP_HDR_BYTES);
    assign pad_last_c = LEN_W'(MIN_PAYLOAD - 1) - len_q;
    assign rd_more_c  = (32'(rd_addr_q) + 1) < 32'(len_q);

    ip_hdr_csum u_csum (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (csum_clr_c),
        .i_en    (csum_en_c),
        .i_word  (csum_word_c),
        .o_csum  (hdr_csum_c)
    );

    // IPv4 header words in wire order; the checksum slot counts as zero
    always_comb begin
        csum_word_c = 16'h0000;
        case (32'(cnt_q))
            0:       csum_word_c = IP_VER_IHL_TOS;
            1:       csum_word_c = tot_len_c;
            2:       csum_word_c = ip_id_q;
            3:       csum_word_c = IP_FLAGS_DF;
            4:       csum_word_c = {IP_TTL, IP_PROTO_UDP};
            6:       csum_word_c = SRC_IP[31:16];
            7:       csum_word_c = SRC_IP[15:0];
            8:       csum_word_c = DST_IP[31:16];
            9:       csum_word_c = DST_IP[15:0];
            default: csum_word_c = 16'h0000;
        endcase
    end

    // Header byte mux keyed on the header byte counter
    always_comb begin
        int unsigned idx;
        idx        = 32'(hdr_cnt_q);
        hdr_byte_c = 8'h00;
        case (idx) inside
            [OFF_DST_MAC : OFF_SRC_MAC - 1]:
                hdr_byte_c = field_byte(DST_MAC, 6, idx - OFF_DST_MAC);
            [OFF_SRC_MAC : OFF_ETYPE - 1]:
                hdr_byte_c = field_byte(SRC_MAC, 6, idx - OFF_SRC_MAC);
            [OFF_ETYPE : OFF_IP_VER - 1]:
                hdr_byte_c = field_byte(48'(ETHERTYPE_IPV4), 2, idx - OFF_ETYPE);
            [OFF_IP_VER : OFF_IP_TOTLEN - 1]:
                hdr_byte_c = field_byte(48'(IP_VER_IHL_TOS), 2, idx - OFF_IP_VER);
            [OFF_IP_TOTLEN : OFF_IP_ID - 1]:
                hdr_byte_c = field_byte(48'(tot_len_c), 2, idx - OFF_IP_TOTLEN);
            [OFF_IP_ID : OFF_IP_FLAGS - 1]:
                hdr_byte_c = field_byte(48'(ip_id_q), 2, idx - OFF_IP_ID);
            [OFF_IP_FLAGS : OFF_IP_TTL - 1]:
                hdr_byte_c = field_byte(48'(IP_FLAGS_DF), 2, idx - OFF_IP_FLAGS);
            [OFF_IP_TTL : OFF_IP_PROTO - 1]:
                hdr_byte_c = IP_TTL;
            [OFF_IP_PROTO : OFF_IP_CSUM - 1]:
                hdr_byte_c = IP_PROTO_UDP;
            [OFF_IP_CSUM : OFF_IP_SRC - 1]:
                hdr_byte_c = field_byte(48'(hdr_csum_c), 2, idx - OFF_IP_CSUM);
            [OFF_IP_SRC : OFF_IP_DST - 1]:
                hdr_byte_c = field_byte(48'(SRC_IP), 4, idx - OFF_IP_SRC);
            [OFF_IP_DST : OFF_UDP_SRC - 1]:
                hdr_byte_c = field_byte(48'(DST_IP), 4, idx - OFF_IP_DST);
            [OFF_UDP_SRC : OFF_UDP_DST - 1]:
                hdr_byte_c = field_byte(48'(SRC_PORT), 2, idx - OFF_UDP_SRC);
            [OFF_UDP_DST : OFF_UDP_LEN - 1]:
                hdr_byte_c = field_byte(48'(DST_PORT), 2, idx - OFF_UDP_DST);
            [OFF_UDP_LEN : OFF_UDP_CSUM - 1]:
                hdr_byte_c = field_byte(48'(udp_len_c), 2, idx - OFF_UDP_LEN);
            [OFF_UDP_CSUM : HDR_BYTES - 1]:
                hdr_byte_c = field_byte(48'(UDP_NO_CSUM), 2, idx - OFF_UDP_CSUM);
            default:
                hdr_byte_c = 8'h00;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        trig_d     = 1'b0;
        data_d     = 8'h00;
        last_d     = 1'b0;
        rd_addr_d  = rd_addr_q;
        len_d      = len_q;
        ip_id_d    = ip_id_q;
        cnt_d      = cnt_q;
        hdr_cnt_d  = hdr_cnt_q;
        csum_clr_c = 1'b0;
        csum_en_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                rd_addr_d = '0;
                cnt_d     = '0;
                hdr_cnt_d = '0;
                if (i_start) begin
                    len_d      = (32'(i_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : i_len;
                    busy_d     = 1'b1;
                    csum_clr_c = 1'b1;
                    state_d    = S_CSUM;
                end
            end
            S_CSUM: begin
                csum_en_c = 1'b1;
                if (cnt_q == LEN_W'(CSUM_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_TRIG;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_TRIG: begin
                trig_d  = 1'b1;
                state_d = S_HDR;
            end
            S_HDR: begin
                trig_d = 1'b1;
                data_d = hdr_byte_c;
                if (hdr_cnt_q == 6'(HDR_BYTES - 1)) begin
                    // Address 0 is already presented; start walking so the
                    // RAM output lines up with the first payload cycle
                    if (rd_more_c) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                    hdr_cnt_d = '0;
                    cnt_d     = '0;
                    state_d   = (len_q != '0) ? S_PAY : S_PAD;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + 6'd1;
                end
            end
            S_PAY: begin
                trig_d = 1'b1;
                data_d = i_rd_data;
                if (rd_more_c) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
                if (cnt_q == len_q - LEN_W'(1)) begin
                    cnt_d = '0;
                    if (32'(len_q) < MIN_PAYLOAD) begin
                        state_d = S_PAD;
                    end else begin
                        last_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_PAD: begin
                trig_d = 1'b1;
                if (cnt_q == pad_last_c) begin
                    cnt_d   = '0;
                    last_d  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_WAIT: begin
                rd_addr_d = '0;
                if (i_tx_over) begin
                    ip_id_d = ip_id_q + 16'd1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            trig_q    <= 1'b0;
            data_q    <= 8'h00;
            last_q    <= 1'b0;
            rd_addr_q <= '0;
            len_q     <= '0;
            ip_id_q   <= 16'h0000;
            cnt_q     <= '0;
            hdr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            trig_q    <= trig_d;
            data_q    <= data_d;
            last_q    <= last_d;
            rd_addr_q <= rd_addr_d;
            len_q     <= len_d;
            ip_id_q   <= ip_id_d;
            cnt_q     <= cnt_d;
            hdr_cnt_q <= hdr_cnt_d;
        end
    end

endmodule

// File: tb/tb_udp_frame_builder.sv
// Self-checking bench for udp_frame_builder: acts as payload RAM and MAC,
// builds each expected frame from the protocol rules and compares the
// captured byte stream, handshake timing and RAM read addresses.
module tb_udp_frame_builder;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [10:0] i_len;
    logic        o_busy;
    logic [10:0] o_rd_addr;
    logic [7:0]  i_rd_data;
    logic        o_tx_trig;
    logic [7:0]  o_data;
    logic        o_last_data;
    logic        i_tx_over;

    logic [7:0]  mem [0:2047];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_ip_id;
    logic [15:0] exp_csum;
    logic [15:0] got_csum;
    logic [7:0]  exp_f[$];

    always #5 i_clk = ~i_clk;

    // Payload RAM with one cycle of read latency
    always @(posedge i_clk) i_rd_data <= mem[o_rd_addr];

    udp_frame_builder dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_tx_trig   (o_tx_trig),
        .o_data      (o_data),
        .o_last_data (o_last_data),
        .i_tx_over   (i_tx_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_f.push_back(8'(v >> (8 * i)));
    endtask

    // Expected frame: Ethernet + IPv4 + UDP header, payload, zero pad to 60
    task automatic build_expected(input int len, input logic [15:0] id);
        int unsigned w [10];
        int unsigned sum;
        w = '{32'h4500, 28 + len, 32'(id), 32'h4000, 32'h4011, 0,
              32'hC0A8, 32'h010A, 32'hC0A8, 32'h0102};
        sum = 0;
        foreach (w[i]) sum += w[i];
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        exp_csum = 16'(~sum);
        exp_f.delete();
        push_be(48'hFFFF_FFFF_FFFF, 6);
        push_be(48'h0012_3456_789A, 6);
        push_be(48'h0800, 2);
        for (int i = 0; i < 5; i++) push_be(48'(w[i]), 2);
        push_be(48'(exp_csum), 2);
        for (int i = 6; i < 10; i++) push_be(48'(w[i]), 2);
        push_be(48'd5000, 2);
        push_be(48'd5001, 2);
        push_be(48'(8 + len), 2);
        push_be(48'h0, 2);
        for (int k = 0; k < len; k++) exp_f.push_back(mem[k]);
        while (exp_f.size() < 60) exp_f.push_back(8'h00);
    endtask

    task automatic run_frame(input int ilen, input bit poke, input bit abort);
        int len, n, r, f, last_idx, last_cnt, bad_bytes, bad_addr, extra, idx;
        logic [7:0]  dq[$];
        logic        lq[$];
        logic [10:0] aq[$];
        len = (ilen > 1472) ? 1472 : ilen;
        build_expected(len, exp_ip_id);
        n = exp_f.size();
        @(negedge i_clk);
        i_start = 1'b1;
        i_len   = 11'(ilen);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("busy_set", 32'(o_busy), 1);
        r = -1;
        f = -1;
        for (int c = 0; c < 3000 && f < 0; c++) begin
            if (c > 0) @(negedge i_clk);
            i_start = 1'b0;
            dq.push_back(o_data);
            lq.push_back(o_last_data);
            aq.push_back(o_rd_addr);
            if (r < 0 && o_tx_trig) r = c;
            else if (r >= 0 && !o_tx_trig) f = c;
            if (abort && r >= 0 && c == r + 43 + 50) begin
                chk("pre_abort_byte50", 32'(o_data), 32'(mem[50]));
                #1 i_rst_n = 1'b0;
                #1 chk("abort_outputs_zero",
                       32'({o_busy, o_tx_trig, o_last_data, o_data, o_rd_addr}), 0);
                @(negedge i_clk);
                i_rst_n   = 1'b1;
                exp_ip_id = 16'h0;
                return;
            end
            if (poke && r >= 0 && c == r + 10) i_start = 1'b1;
        end
        chk("trig_rise", 32'(r >= 0), 1);
        chk("trig_fall", 32'(f >= 0), 1);
        if (r < 0 || f < 0) return;
        chk("frame_len", 32'(f - r - 1), 32'(n));
        bad_bytes = 0;
        for (int i = 0; i < n; i++) begin
            idx = r + 1 + i;
            if (idx >= dq.size() || dq[idx] !== exp_f[i]) bad_bytes++;
        end
        chk("frame_bytes_bad", 32'(bad_bytes), 0);
        last_cnt = 0;
        last_idx = -1;
        foreach (lq[i]) if (lq[i] === 1'b1) begin last_cnt++; last_idx = i; end
        chk("last_count", 32'(last_cnt), 1);
        chk("last_pos", 32'(last_idx - r - 1), 32'(n - 1));
        chk("tail_zero", 32'({dq[f], lq[f]}), 0);
        bad_addr = 0;
        if (len == 0) begin
            foreach (aq[i]) if (aq[i] !== 11'd0) bad_addr++;
        end else begin
            for (int k = 0; k < len; k++) begin
                idx = r + 41 + k;
                if (idx >= aq.size() || aq[idx] !== 11'(k)) bad_addr++;
            end
        end
        chk("rd_addr_bad", 32'(bad_addr), 0);
        if (f - r - 1 >= 42) begin
            got_csum = {dq[r + 25], dq[r + 26]};
            chk("ip_csum", 32'(got_csum), 32'(exp_csum));
            chk("tot_len", 32'({dq[r + 17], dq[r + 18]}), 32'(28 + len));
            chk("ip_id", 32'({dq[r + 19], dq[r + 20]}), 32'(exp_ip_id));
            chk("udp_len", 32'({dq[r + 39], dq[r + 40]}), 32'(8 + len));
        end
        repeat ($urandom_range(1, 4)) @(negedge i_clk);
        chk("busy_in_wait", 32'(o_busy), 1);
        i_tx_over = 1'b1;
        if (poke) i_start = 1'b1;
        @(negedge i_clk);
        i_tx_over = 1'b0;
        i_start   = 1'b0;
        chk("busy_clear", 32'(o_busy), 0);
        exp_ip_id = exp_ip_id + 16'd1;
        extra = 0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_tx_trig || o_busy) extra++;
        end
        chk("no_extra_frame", 32'(extra), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_len     = 11'd0;
        i_tx_over = 1'b0;
        exp_ip_id = 16'h0;
        got_csum  = 16'h0;
        for (int k = 0; k < 2048; k++) mem[k] = 8'($urandom);
        #12;
        chk("reset_outputs", 32'({o_busy, o_tx_trig, o_last_data, o_data, o_rd_addr}), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        run_frame(100, 1'b0, 1'b0);
        chk("len100_csum_const", 32'(got_csum), 32'hB710);
        run_frame(5, 1'b0, 1'b0);
        run_frame(0, 1'b0, 1'b0);
        run_frame(2000, 1'b0, 1'b0);
        run_frame(300, 1'b1, 1'b0);
        run_frame(int'($urandom_range(0, 1472)), 1'b0, 1'b0);
        run_frame(400, 1'b0, 1'b1);
        run_frame(100, 1'b0, 1'b0);
        chk("post_reset_csum_const", 32'(got_csum), 32'hB710);
        for (int i = 0; i < 4; i++) run_frame(int'($urandom_range(0, 2047)), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
